rnd_range_picker: RTL and testbench

Consumer side of the free-running 8-bit LFSR random stream. On request, it turns the raw `rnd` byte into an unbiased value in [0, MAX_VAL] using mask-and-reject sampling, then presents the value on a valid/ready output. Game logic uses it for spawn positions and object speeds. A bounded retry count guarantees a result in finite time.

---
 rtl/rnd_range_picker.sv | 143 ++++++++++++++
 tb/tb_rnd_range_picker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rnd_range_picker.sv
// rnd_range_picker: turns a raw LFSR byte into an unbiased value in [0, MAX_VAL] by mask-and-reject sampling.
// Latency: 2 cycles minimum (req -> out_valid), MAX_TRIES+1 worst case; bounded by a fallback after MAX_TRIES rejects.
// Backpressure: result is held stable in HOLD until out_ready; req is only sampled in IDLE or at the HOLD handshake.
// Optional feature macro: RND_NO_REPEAT_EN (reject a candidate equal to the previously delivered value).
module rnd_range_picker #(
  parameter int MAX_VAL   = 99,
  parameter int MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rnd,
  input  logic       req,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_val,
  output logic       fallback,
  output logic [3:0] tries,
  output logic       busy
);

  // Smallest 2^k-1 covering MAX_VAL; keeps the reject probability below one half.
  function automatic int calc_mask(input int mv);
    int m;
    m = 0;
    for (int k = 0; k < 8; k++) begin
      if (m < mv) m = m * 2 + 1;
    end
    return m;
  endfunction

  localparam logic [7:0] MASK    = 8'(calc_mask(MAX_VAL));
  localparam logic [7:0] MAXV    = 8'(MAX_VAL);
  localparam logic [7:0] OFFS    = 8'(MAX_VAL + 1);
  localparam logic [3:0] TRY_LIM = 4'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] out_val_q, out_val_d;
  logic       fallback_q, fallback_d;
  logic [3:0] tries_q, tries_d;
  logic [3:0] cnt_q, cnt_d;

  logic [7:0] cand;
  logic       in_range;
  logic       rep_hit;

  assign cand     = rnd & MASK;
  assign in_range = (cand <= MAXV);

`ifdef RND_NO_REPEAT_EN
  logic [7:0] last_val_q, last_val_d;
  logic       last_valid_q, last_valid_d;

  // A one-value range cannot avoid repeats, so the check is switched off there.
  assign rep_hit = (MAX_VAL != 0) && last_valid_q && (cand == last_val_q);
`else
  assign rep_hit = 1'b0;
`endif

  // Next-state and datapath update for the IDLE/SAMPLE/HOLD controller.
  always_comb begin
    state_d    = state_q;
    out_val_d  = out_val_q;
    fallback_d = fallback_q;
    tries_d    = tries_q;
    cnt_d      = cnt_q;
`ifdef RND_NO_REPEAT_EN
    last_val_d   = last_val_q;
    last_valid_d = last_valid_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_SAMPLE;
          cnt_d   = 4'd0;
        end
      end
      S_SAMPLE: begin
        cnt_d = cnt_q + 4'd1;
        if (in_range && !rep_hit) begin
          out_val_d  = cand;
          fallback_d = 1'b0;
          tries_d    = cnt_d;
          state_d    = S_HOLD;
        end else if (cnt_d == TRY_LIM) begin
          // Out-of-range fold stays in range since MASK <= 2*MAX_VAL+1; a repeat-only reject keeps cand.
          out_val_d  = in_range ? cand : (cand - OFFS);
          fallback_d = 1'b1;
          tries_d    = TRY_LIM;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
`ifdef RND_NO_REPEAT_EN
          last_val_d   = out_val_q;
          last_valid_d = 1'b1;
`endif
          cnt_d   = 4'd0;
          state_d = req ? S_SAMPLE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      out_val_q  <= 8'd0;
      fallback_q <= 1'b0;
      tries_q    <= 4'd0;
      cnt_q      <= 4'd0;
`ifdef RND_NO_REPEAT_EN
      last_val_q   <= 8'd0;
      last_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      out_val_q  <= out_val_d;
      fallback_q <= fallback_d;
      tries_q    <= tries_d;
      cnt_q      <= cnt_d;
`ifdef RND_NO_REPEAT_EN
      last_val_q   <= last_val_d;
      last_valid_q <= last_valid_d;
`endif
    end
  end

  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q == S_SAMPLE);
  assign out_val   = out_val_q;
  assign fallback  = fallback_q;
  assign tries     = tries_q;

endmodule

// File: tb/tb_rnd_range_picker.sv
// Self-checking bench for rnd_range_picker: directed cases plus randomized picks against a transaction-level model.
// Expected results come from the range/mask rules applied to the byte sequence the bench itself drives.
module tb_rnd_range_picker;
  localparam int MAX_VAL   = 99;
  localparam int MAX_TRIES = 8;
`ifdef RND_NO_REPEAT_EN
  localparam bit NOREP = 1'b1;
`else
  localparam bit NOREP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rnd = 8'd0;
  logic       req = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_val;
  logic       fallback;
  logic [3:0] tries;
  logic       busy;

  rnd_range_picker #(.MAX_VAL(MAX_VAL), .MAX_TRIES(MAX_TRIES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rnd       (rnd),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_val   (out_val),
    .fallback  (fallback),
    .tries     (tries),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rv [16];
  int  mask;
  bit  m_lv;
  int  m_lval;
  int  e_val, e_fb, e_tries;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Walk the driven byte sequence and decide which candidate the picker must deliver.
  function automatic void predict();
    int  c;
    bit  rej;
    for (int i = 0; i < MAX_TRIES; i++) begin
      c   = int'(rv[i]) & mask;
      rej = (c > MAX_VAL) || (NOREP && m_lv && c == m_lval && MAX_VAL != 0);
      if (!rej) begin
        e_val = c; e_fb = 0; e_tries = i + 1;
        return;
      end
      if (i == MAX_TRIES - 1) begin
        e_val = (c > MAX_VAL) ? ((c - (MAX_VAL + 1)) & 255) : c;
        e_fb = 1; e_tries = MAX_TRIES;
      end
    end
  endfunction

  // Called just after the posedge that moved the DUT into SAMPLE.
  task automatic run_sample();
    predict();
    rnd = rv[0];
    check("busy_in_sample", busy, 1);
    check("valid_before_result", out_valid, 0);
    for (int i = 0; i < MAX_TRIES; i++) begin
      @(posedge clk); #1;
      if (i + 1 < e_tries) begin
        check("valid_before_result", out_valid, 0);
        rnd = rv[i + 1];
      end else begin
        check("result_valid", out_valid, 1);
        check("result_val", out_val, e_val);
        check("result_fallback", fallback, e_fb);
        check("result_tries", tries, e_tries);
        check("result_not_busy", busy, 0);
        break;
      end
    end
  endtask

  task automatic start_pick();
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    run_sample();
  endtask

  // Hold off the consumer for a while, then hand-shake; optionally request the next pick at once.
  task automatic deliver(input int waitc, input bit nxt);
    out_ready = 1'b0;
    repeat (waitc) begin
      rnd = 8'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_val_stable", out_val, e_val);
    end
    out_ready = 1'b1;
    req = nxt;
    @(posedge clk); #1;
    out_ready = 1'b0;
    req = 1'b0;
    m_lv = 1'b1;
    m_lval = e_val;
    check("valid_drop", out_valid, 0);
    check("busy_after_handshake", busy, nxt);
  endtask

  task automatic fill_all(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rv[i] = v;
  endtask

  initial begin
    bit pend;
    mask = (1 << $clog2(MAX_VAL + 1)) - 1;
    m_lv = 1'b0;
    m_lval = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_val", out_val, 0);
    check("rst_fallback", fallback, 0);
    check("rst_tries", tries, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // First-candidate accept: 0xC8 & 127 = 72.
    fill_all(8'h00); rv[0] = 8'hC8;
    start_pick();
    deliver(0, 1'b0);

    // Two rejects then 49, held for five cycles, then back-to-back request.
    fill_all(8'h00); rv[0] = 8'h7F; rv[1] = 8'h65; rv[2] = 8'h31;
    start_pick();
    deliver(5, 1'b1);

    // All rejects: fallback 127-100 = 27.
    fill_all(8'h7F);
    run_sample();
    deliver(0, 1'b0);

    // Reset in the middle of SAMPLE.
    fill_all(8'h7F);
    req = 1'b1; @(posedge clk); #1; req = 1'b0; rnd = 8'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_lv = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_val", out_val, 0);
    check("mid_rst_fallback", fallback, 0);
    check("mid_rst_tries", tries, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    check("post_rst_idle", busy, 0);

    // First pick after reset may equal the pre-reset value (27).
    fill_all(8'h00); rv[0] = 8'h1B;
    start_pick();
    deliver(1, 1'b0);

    // Deliver 40, then offer 40 again followed by 41.
    fill_all(8'h00); rv[0] = 8'h28;
    start_pick();
    deliver(0, 1'b0);
    fill_all(8'h00); rv[0] = 8'h28; rv[1] = 8'h29;
    start_pick();
    deliver(0, 1'b0);

    // Randomized picks, biased toward rejects so fallbacks occur.
    pend = 1'b0;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) rv[i] = 8'($urandom);
        else rv[i] = 8'($urandom_range(100, 127)) | (8'($urandom_range(0, 1)) << 7);
      end
      if (pend) run_sample();
      else start_pick();
      pend = 1'($urandom_range(0, 1));
      deliver($urandom_range(0, 3), pend);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
